// File: rtl/stopwatch_n.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_n
// Brief    : Elapsed-cycle stopwatch. 'first' clears and arms the counter,
//            'done' captures the count into a result register that is held
//            until the consumer accepts it with 'result_ready'. Overflow is
//            sticky per measurement and either saturates or wraps the count.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_n #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             first,
    input  logic             done,
    input  logic             result_ready,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             overflow,
    output logic             running
);

    localparam logic [WIDTH-1:0] c_max = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_result_valid;
    logic             r_overflow;
    logic             r_running;

    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_result_valid_nxt;
    logic             w_overflow_nxt;
    logic [WIDTH-1:0] w_inc;
    logic             w_at_max;

    assign w_at_max = (r_count == c_max);

    // Overflow behaviour of the incrementer is fixed at elaboration time.
    generate
        if (SATURATE) begin : g_saturate
            assign w_inc = w_at_max ? c_max : (r_count + 1'b1);
        end else begin : g_wrap
            assign w_inc = r_count + 1'b1;
        end
    endgenerate

    // Next-state and next-output decode; first beats done beats result_ready.
    always_comb begin
        w_state_nxt        = r_state;
        w_count_nxt        = r_count;
        w_result_nxt       = r_result;
        w_result_valid_nxt = r_result_valid;
        w_overflow_nxt     = r_overflow;

        if (first) begin
            // Restart from any state; a pending result is dropped but the
            // result register itself keeps its last value.
            w_state_nxt        = S_RUN;
            w_count_nxt        = '0;
            w_overflow_nxt     = 1'b0;
            w_result_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (done) begin
                        w_state_nxt        = S_HOLD;
                        w_result_nxt       = r_count;
                        w_result_valid_nxt = 1'b1;
                    end else begin
                        w_count_nxt = w_inc;
                        if (w_at_max) begin
                            w_overflow_nxt = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (result_ready) begin
                        w_state_nxt        = S_IDLE;
                        w_result_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_count        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_overflow     <= 1'b0;
            r_running      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_count        <= w_count_nxt;
            r_result       <= w_result_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_overflow     <= w_overflow_nxt;
            r_running      <= (w_state_nxt == S_RUN);
        end
    end

    assign count        = r_count;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign overflow     = r_overflow;
    assign running      = r_running;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_n
// Brief    : Directed self-checking bench for stopwatch_n, WIDTH=4, with one
//            saturating and one wrapping instance driven by shared inputs.
//            Observed vector layout: {count, result, valid, overflow, running}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_n;

    logic       clk;
    logic       rst_n;
    logic       first;
    logic       done;
    logic       result_ready;

    logic [3:0] count_s, result_s, count_w, result_w;
    logic       rv_s, ov_s, run_s, rv_w, ov_w, run_w;
    logic [10:0] obs_s, obs_w;

    int total;
    int bad;

    stopwatch_n #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .first(first), .done(done),
        .result_ready(result_ready), .count(count_s), .result(result_s),
        .result_valid(rv_s), .overflow(ov_s), .running(run_s)
    );

    stopwatch_n #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .first(first), .done(done),
        .result_ready(result_ready), .count(count_w), .result(result_w),
        .result_valid(rv_w), .overflow(ov_w), .running(run_w)
    );

    assign obs_s = {count_s, result_s, rv_s, ov_s, run_s};
    assign obs_w = {count_w, result_w, rv_w, ov_w, run_w};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle so outputs are read away from the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; first = 1'b0; done = 1'b0; result_ready = 1'b0;
        #2;
        if (obs_s !== 11'd0) begin $display("FAIL reset_sat got=%h want=%h", obs_s, 11'd0); bad++; end
        total++;
        if (obs_w !== 11'd0) begin $display("FAIL reset_wrap got=%h want=%h", obs_w, 11'd0); bad++; end
        total++;
        step(2);
        rst_n = 1'b1;
        done = 1'b1;
        step(2);
        done = 1'b0;
        if (obs_s !== 11'd0) begin $display("FAIL idle_after_reset got=%h want=%h", obs_s, 11'd0); bad++; end
        total++;
    endtask

    task automatic test_basic();
        first = 1'b1; step(1); first = 1'b0;
        step(4);
        if (obs_s !== {4'd4, 4'd0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL basic_run got=%h want=%h", obs_s, {4'd4, 4'd0, 3'b001}); bad++; end
        total++;
        done = 1'b1; step(1); done = 1'b0;
        if (obs_s !== {4'd4, 4'd4, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL basic_capture got=%h want=%h", obs_s, {4'd4, 4'd4, 3'b100}); bad++; end
        total++;
        result_ready = 1'b1; step(1); result_ready = 1'b0;
    endtask

    task automatic test_overflow();
        first = 1'b1; step(1); first = 1'b0;
        step(15);
        if (obs_s !== {4'd15, 4'd4, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL at_max_no_ovf got=%h want=%h", obs_s, {4'd15, 4'd4, 3'b001}); bad++; end
        total++;
        step(1);
        if (obs_s !== {4'd15, 4'd4, 1'b0, 1'b1, 1'b1}) begin
            $display("FAIL saturate16 got=%h want=%h", obs_s, {4'd15, 4'd4, 3'b011}); bad++; end
        total++;
        if (obs_w !== {4'd0, 4'd4, 1'b0, 1'b1, 1'b1}) begin
            $display("FAIL wrap16 got=%h want=%h", obs_w, {4'd0, 4'd4, 3'b011}); bad++; end
        total++;
        step(1);
        if (obs_s !== {4'd15, 4'd4, 1'b0, 1'b1, 1'b1}) begin
            $display("FAIL saturate17 got=%h want=%h", obs_s, {4'd15, 4'd4, 3'b011}); bad++; end
        total++;
        if (obs_w !== {4'd1, 4'd4, 1'b0, 1'b1, 1'b1}) begin
            $display("FAIL wrap17 got=%h want=%h", obs_w, {4'd1, 4'd4, 3'b011}); bad++; end
        total++;
        done = 1'b1; step(1); done = 1'b0;
        if (obs_s !== {4'd15, 4'd15, 1'b1, 1'b1, 1'b0}) begin
            $display("FAIL saturate_capture got=%h want=%h", obs_s, {4'd15, 4'd15, 3'b110}); bad++; end
        total++;
        if (obs_w !== {4'd1, 4'd1, 1'b1, 1'b1, 1'b0}) begin
            $display("FAIL wrap_capture got=%h want=%h", obs_w, {4'd1, 4'd1, 3'b110}); bad++; end
        total++;
        result_ready = 1'b1; step(1); result_ready = 1'b0;
        if (obs_s !== {4'd15, 4'd15, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL saturate_release got=%h want=%h", obs_s, {4'd15, 4'd15, 3'b010}); bad++; end
        total++;
    endtask

    task automatic test_handshake();
        first = 1'b1; step(1); first = 1'b0;
        step(3);
        done = 1'b1; step(1); done = 1'b0;
        // done held in HOLD must not re-capture or advance anything
        for (int i = 0; i < 10; i++) begin
            done = (i % 3) == 0;
            step(1);
            if (obs_s !== {4'd3, 4'd3, 1'b1, 1'b0, 1'b0}) begin
                $display("FAIL hold_stable[%0d] got=%h want=%h", i, obs_s, {4'd3, 4'd3, 3'b100}); bad++; end
            total++;
        end
        done = 1'b0;
        result_ready = 1'b1; step(1); result_ready = 1'b0;
        if (obs_s !== {4'd3, 4'd3, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL release got=%h want=%h", obs_s, {4'd3, 4'd3, 3'b000}); bad++; end
        total++;
        done = 1'b1; step(1); done = 1'b0;
        result_ready = 1'b1; step(1); result_ready = 1'b0;
        if (obs_s !== {4'd3, 4'd3, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL idle_ignores got=%h want=%h", obs_s, {4'd3, 4'd3, 3'b000}); bad++; end
        total++;
    endtask

    task automatic test_collision();
        first = 1'b1; step(3);
        if (obs_s !== {4'd0, 4'd3, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL first_held got=%h want=%h", obs_s, {4'd0, 4'd3, 3'b001}); bad++; end
        total++;
        first = 1'b0; step(2);
        first = 1'b1; done = 1'b1; step(1); first = 1'b0; done = 1'b0;
        if (obs_s !== {4'd0, 4'd3, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL first_done got=%h want=%h", obs_s, {4'd0, 4'd3, 3'b001}); bad++; end
        total++;
        step(2);
        done = 1'b1; step(1); done = 1'b0;
        if (obs_s !== {4'd2, 4'd2, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL capture2 got=%h want=%h", obs_s, {4'd2, 4'd2, 3'b100}); bad++; end
        total++;
        first = 1'b1; result_ready = 1'b1; step(1); first = 1'b0; result_ready = 1'b0;
        if (obs_s !== {4'd0, 4'd2, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL first_ready got=%h want=%h", obs_s, {4'd0, 4'd2, 3'b001}); bad++; end
        total++;
    endtask

    task automatic test_async_reset();
        step(9);
        if (obs_s !== {4'd9, 4'd2, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL pre_reset got=%h want=%h", obs_s, {4'd9, 4'd2, 3'b001}); bad++; end
        total++;
        #3 rst_n = 1'b0;
        #1;
        if (obs_s !== 11'd0) begin $display("FAIL async_sat got=%h want=%h", obs_s, 11'd0); bad++; end
        total++;
        if (obs_w !== 11'd0) begin $display("FAIL async_wrap got=%h want=%h", obs_w, 11'd0); bad++; end
        total++;
        step(1);
        rst_n = 1'b1;
        done = 1'b1; step(2); done = 1'b0;
        if (obs_s !== 11'd0) begin $display("FAIL done_after_reset got=%h want=%h", obs_s, 11'd0); bad++; end
        total++;
        first = 1'b1; step(1); first = 1'b0;
        step(1);
        if (obs_s !== {4'd1, 4'd0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL rearm got=%h want=%h", obs_s, {4'd1, 4'd0, 3'b001}); bad++; end
        total++;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_handshake();
        test_collision();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
